s_to_p_framed: RTL and testbench

S_TO_P_FRAMED -- requirements
Module: s_to_p_framed

---
 rtl/s_to_p_pkg.sv | 25 ++
 rtl/s_to_p_out_reg.sv | 57 +++++
 rtl/s_to_p_framed.sv | 96 +++++++++
 tb/tb_s_to_p_framed.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/s_to_p_pkg.sv
// ---------------------------------------------------------------------------
// s_to_p_pkg : shared helpers for the framed serial-to-parallel block
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package s_to_p_pkg;

  function automatic int count_width(input int lanes);
    return $clog2(lanes + 1);
  endfunction

  // Reverses the low 'bits' bits of idx.
  function automatic int unsigned bitrev(input int unsigned idx, input int bits);
    int unsigned r;
    r = '0;
    for (int b = 0; b < bits; b++) begin
      r[bits-1-b] = idx[b];
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/s_to_p_out_reg.sv
// ---------------------------------------------------------------------------
// s_to_p_out_reg : output frame holding register with valid/ready handshake
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module s_to_p_out_reg #(
  parameter int                 DATA_W   = 32,
  parameter int                 COUNT_W  = 3,
  parameter logic [DATA_W-1:0]  RST_DATA = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic [DATA_W-1:0]  i_frame,
  input  logic [COUNT_W-1:0] i_count,
  input  logic               i_last,
  input  logic               i_out_ready,
  output logic               o_in_ready,
  output logic [DATA_W-1:0]  o_data,
  output logic               o_valid,
  output logic [COUNT_W-1:0] o_count,
  output logic               o_last
);

  logic [DATA_W-1:0]  r_data;
  logic               r_valid;
  logic [COUNT_W-1:0] r_count;
  logic               r_last;

  assign o_in_ready = !r_valid || i_out_ready;

  // A load on the same edge as a consume replaces the frame and keeps valid high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= RST_DATA;
      r_valid <= 1'b0;
      r_count <= '0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_frame;
      r_valid <= 1'b1;
      r_count <= i_count;
      r_last  <= i_last;
    end else if (r_valid && i_out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_count = r_count;
  assign o_last  = r_last;

endmodule

`default_nettype wire

// File: rtl/s_to_p_framed.sv
// ---------------------------------------------------------------------------
// s_to_p_framed : packs IN_WIDTH-bit words into OUT_WIDTH-lane frames,
// closing short frames on i_last. Optional macro S_TO_P_BITREV_EN.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module s_to_p_framed
  import s_to_p_pkg::*;
#(
  parameter int                  IN_WIDTH  = 8,
  parameter int                  OUT_WIDTH = 4,
  parameter logic [IN_WIDTH-1:0] PAD_VALUE = '0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [IN_WIDTH-1:0]                 i_data,
  input  logic                                i_valid,
  output logic                                i_ready,
  input  logic                                i_last,
  output logic [IN_WIDTH*OUT_WIDTH-1:0]       o_data,
  output logic                                o_valid,
  input  logic                                o_ready,
  output logic                                o_last,
  output logic [count_width(OUT_WIDTH)-1:0]   o_count
);

  localparam int c_idx_w   = $clog2(OUT_WIDTH);
  localparam int c_cnt_w   = count_width(OUT_WIDTH);
  localparam int c_frame_w = IN_WIDTH * OUT_WIDTH;
  localparam logic [c_frame_w-1:0] c_pad_frame = {OUT_WIDTH{PAD_VALUE}};

  logic [c_idx_w-1:0]   r_cnt;
  logic [c_frame_w-1:0] r_lanes;
  logic [c_idx_w-1:0]   w_lane;
  logic [c_frame_w-1:0] w_frame;
  logic [c_cnt_w-1:0]   w_count;
  logic                 w_accept;
  logic                 w_done;

`ifdef S_TO_P_BITREV_EN
  if ((1 << c_idx_w) != OUT_WIDTH) begin : g_pow2_check
    $error("OUT_WIDTH must be a power of two with bit-reversed lane order");
  end
  assign w_lane = c_idx_w'(bitrev(32'(r_cnt), c_idx_w));
`else
  assign w_lane = r_cnt;
`endif

  assign w_accept = i_valid && i_ready;
  assign w_done   = w_accept && ((r_cnt == c_idx_w'(OUT_WIDTH - 1)) || i_last);
  assign w_count  = c_cnt_w'(r_cnt) + c_cnt_w'(1);

  // Collected lanes with the incoming word merged into its target lane.
  for (genvar k = 0; k < OUT_WIDTH; k++) begin : g_lane
    assign w_frame[k*IN_WIDTH +: IN_WIDTH] =
      (w_lane == c_idx_w'(k)) ? i_data : r_lanes[k*IN_WIDTH +: IN_WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_lanes <= c_pad_frame;
    end else if (w_accept) begin
      if (w_done) begin
        r_cnt   <= '0;
        r_lanes <= c_pad_frame;
      end else begin
        r_cnt   <= r_cnt + c_idx_w'(1);
        r_lanes <= w_frame;
      end
    end
  end

  s_to_p_out_reg #(
    .DATA_W   (c_frame_w),
    .COUNT_W  (c_cnt_w),
    .RST_DATA (c_pad_frame)
  ) u_out_reg (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_done),
    .i_frame     (w_frame),
    .i_count     (w_count),
    .i_last      (i_last),
    .i_out_ready (o_ready),
    .o_in_ready  (i_ready),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_count     (o_count),
    .o_last      (o_last)
  );

endmodule

`default_nettype wire

// File: tb/tb_s_to_p_framed.sv
// ---------------------------------------------------------------------------
// tb_s_to_p_framed : directed and scoreboarded bench for s_to_p_framed
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_s_to_p_framed;

  localparam int IW = 8;
  localparam int OW = 4;
  localparam int CW = 3;
  localparam int FW = IW * OW;

`ifdef S_TO_P_BITREV_EN
  localparam logic [FW-1:0] c_exp_full  = 32'hEFADBEDE;
  localparam logic [FW-1:0] c_exp_short = 32'h00AD00DE;
  localparam logic [FW-1:0] c_exp_lastf = 32'h04020301;
  localparam logic [FW-1:0] c_exp_bp0   = 32'h13111210;
  localparam logic [FW-1:0] c_exp_bp1   = 32'h17151614;
  localparam logic [FW-1:0] c_exp_rst   = 32'h44223311;
`else
  localparam logic [FW-1:0] c_exp_full  = 32'hEFBEADDE;
  localparam logic [FW-1:0] c_exp_short = 32'h0000ADDE;
  localparam logic [FW-1:0] c_exp_lastf = 32'h04030201;
  localparam logic [FW-1:0] c_exp_bp0   = 32'h13121110;
  localparam logic [FW-1:0] c_exp_bp1   = 32'h17161514;
  localparam logic [FW-1:0] c_exp_rst   = 32'h44332211;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [IW-1:0] i_data = '0;
  logic          i_valid = 1'b0;
  logic          i_ready;
  logic          i_last = 1'b0;
  logic [FW-1:0] o_data;
  logic          o_valid;
  logic          o_ready = 1'b1;
  logic          o_last;
  logic [CW-1:0] o_count;

  int n_cmp  = 0;
  int n_fail = 0;

  logic          s_acc, s_took, s_last, s_olast;
  logic [IW-1:0] s_data;
  logic [FW-1:0] s_odata;
  logic [CW-1:0] s_ocount;

  typedef struct packed {
    logic [FW-1:0] d;
    logic [CW-1:0] c;
    logic          l;
  } frm_t;

  s_to_p_framed dut (
    .clk     (clk),
    .rst     (rst),
    .i_data  (i_data),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .i_last  (i_last),
    .o_data  (o_data),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_last  (o_last),
    .o_count (o_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Samples handshakes mid-cycle, then returns 1 time unit after the next rising edge.
  task automatic tick();
    @(negedge clk);
    s_acc    = i_valid && i_ready;
    s_took   = o_valid && o_ready;
    s_data   = i_data;
    s_last   = i_last;
    s_odata  = o_data;
    s_ocount = o_count;
    s_olast  = o_last;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [IW-1:0] d, input logic l);
    int budget;
    i_valid = 1'b1;
    i_data  = d;
    i_last  = l;
    budget  = 50;
    do begin
      tick();
      budget--;
    end while (!s_acc && budget > 0);
    if (!s_acc) begin
      n_cmp++; n_fail++;
      $display("FAIL send_timeout: word %h not accepted within 50 cycles", d);
    end
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_o_valid: got %b want 0", o_valid); end
    n_cmp++; if (o_last !== 1'b0) begin n_fail++; $display("FAIL reset_o_last: got %b want 0", o_last); end
    n_cmp++; if (o_count !== 3'd0) begin n_fail++; $display("FAIL reset_o_count: got %0d want 0", o_count); end
    n_cmp++; if (o_data !== 32'h0) begin n_fail++; $display("FAIL reset_o_data: got %h want 00000000", o_data); end
    n_cmp++; if (i_ready !== 1'b1) begin n_fail++; $display("FAIL reset_i_ready: got %b want 1", i_ready); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();
    n_cmp++; if (i_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_i_ready: got %b want 1", i_ready); end
  endtask

  task automatic test_full_frame();
    o_ready = 1'b1;
    send_word(8'hDE, 1'b0);
    send_word(8'hAD, 1'b0);
    send_word(8'hBE, 1'b0);
    n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL full_early_valid: got %b want 0", o_valid); end
    send_word(8'hEF, 1'b0);
    n_cmp++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL full_valid: got %b want 1", o_valid); end
    n_cmp++; if (o_data !== c_exp_full) begin n_fail++; $display("FAIL full_data: got %h want %h", o_data, c_exp_full); end
    n_cmp++; if (o_count !== 3'd4) begin n_fail++; $display("FAIL full_count: got %0d want 4", o_count); end
    n_cmp++; if (o_last !== 1'b0) begin n_fail++; $display("FAIL full_last: got %b want 0", o_last); end
    tick();
    n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL full_consumed: got %b want 0", o_valid); end
  endtask

  task automatic test_short_frame();
    send_word(8'hDE, 1'b0);
    send_word(8'hAD, 1'b1);
    n_cmp++; if (o_data !== c_exp_short) begin n_fail++; $display("FAIL short_data: got %h want %h", o_data, c_exp_short); end
    n_cmp++; if (o_count !== 3'd2) begin n_fail++; $display("FAIL short_count: got %0d want 2", o_count); end
    n_cmp++; if (o_last !== 1'b1) begin n_fail++; $display("FAIL short_last: got %b want 1", o_last); end
    send_word(8'h11, 1'b1);
    n_cmp++; if (o_data !== 32'h00000011) begin n_fail++; $display("FAIL single_data: got %h want 00000011", o_data); end
    n_cmp++; if (o_count !== 3'd1) begin n_fail++; $display("FAIL single_count: got %0d want 1", o_count); end
    n_cmp++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", o_valid); end
    tick();
  endtask

  task automatic test_last_on_full();
    send_word(8'h01, 1'b0);
    send_word(8'h02, 1'b0);
    send_word(8'h03, 1'b0);
    send_word(8'h04, 1'b1);
    n_cmp++; if (o_data !== c_exp_lastf) begin n_fail++; $display("FAIL lastfull_data: got %h want %h", o_data, c_exp_lastf); end
    n_cmp++; if (o_count !== 3'd4) begin n_fail++; $display("FAIL lastfull_count: got %0d want 4", o_count); end
    n_cmp++; if (o_last !== 1'b1) begin n_fail++; $display("FAIL lastfull_last: got %b want 1", o_last); end
    tick();
    n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL lastfull_extra_frame: got %b want 0", o_valid); end
  endtask

  task automatic test_backpressure();
    logic [IW-1:0] words [8];
    logic [FW-1:0] got [2];
    int idx, nf;
    for (int i = 0; i < 8; i++) words[i] = IW'(8'h10 + i);
    idx = 0; nf = 0;
    o_ready = 1'b0;
    i_valid = 1'b1;
    i_data  = words[0];
    for (int c = 0; c < 14; c++) begin
      tick();
      if (s_acc) begin idx++; if (idx < 8) i_data = words[idx]; end
      if (c >= 4) begin
        n_cmp++; if (o_data !== c_exp_bp0) begin n_fail++; $display("FAIL bp_hold_data: got %h want %h", o_data, c_exp_bp0); end
        n_cmp++; if (i_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold_i_ready: got %b want 0", i_ready); end
      end
    end
    n_cmp++; if (idx != 4) begin n_fail++; $display("FAIL bp_words_taken: got %0d want 4", idx); end
    o_ready = 1'b1;
    for (int c = 0; c < 30 && nf < 2; c++) begin
      tick();
      if (s_took) begin got[nf] = s_odata; nf++; end
      if (s_acc) begin idx++; if (idx < 8) i_data = words[idx]; else i_valid = 1'b0; end
    end
    i_valid = 1'b0;
    n_cmp++; if (nf != 2) begin n_fail++; $display("FAIL bp_frames: got %0d want 2", nf); end
    n_cmp++; if (got[0] !== c_exp_bp0) begin n_fail++; $display("FAIL bp_frame0: got %h want %h", got[0], c_exp_bp0); end
    n_cmp++; if (got[1] !== c_exp_bp1) begin n_fail++; $display("FAIL bp_frame1: got %h want %h", got[1], c_exp_bp1); end
    n_cmp++; if (idx != 8) begin n_fail++; $display("FAIL bp_words_total: got %0d want 8", idx); end
  endtask

  task automatic test_reset_mid();
    o_ready = 1'b1;
    send_word(8'hAA, 1'b0);
    send_word(8'hBB, 1'b0);
    rst = 1'b1;
    #2;
    n_cmp++; if (i_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_i_ready: got %b want 1", i_ready); end
    rst = 1'b0;
    repeat (3) tick();
    n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b want 0", o_valid); end
    send_word(8'h11, 1'b0);
    send_word(8'h22, 1'b0);
    send_word(8'h33, 1'b0);
    send_word(8'h44, 1'b0);
    n_cmp++; if (o_data !== c_exp_rst) begin n_fail++; $display("FAIL midrst_data: got %h want %h", o_data, c_exp_rst); end
    n_cmp++; if (o_count !== 3'd4) begin n_fail++; $display("FAIL midrst_count: got %0d want 4", o_count); end
    tick();
  endtask

  function automatic int lane_of(input int c);
`ifdef S_TO_P_BITREV_EN
    return ((c & 1) << 1) | ((c >> 1) & 1);
`else
    return c;
`endif
  endfunction

  task automatic test_random();
    logic [IW-1:0] m_lanes [OW];
    frm_t q[$];
    frm_t f, e;
    int m_cnt, sent, cyc;
    for (int k = 0; k < OW; k++) m_lanes[k] = '0;
    m_cnt = 0; sent = 0; cyc = 0;
    while ((sent < 400 || q.size() > 0) && cyc < 5000) begin
      if (sent < 400) begin
        i_valid = ($urandom_range(0, 3) != 0);
        i_data  = IW'($urandom);
        i_last  = ($urandom_range(0, 7) == 0);
        o_ready = ($urandom_range(0, 2) != 0);
      end else begin
        i_valid = 1'b0;
        i_last  = 1'b0;
        o_ready = 1'b1;
      end
      tick();
      cyc++;
      if (s_took) begin
        if (q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL rand_unexpected_frame: got %h want none", s_odata);
        end else begin
          e = q.pop_front();
          n_cmp++; if (s_odata !== e.d) begin n_fail++; $display("FAIL rand_data: got %h want %h", s_odata, e.d); end
          n_cmp++; if (s_ocount !== e.c) begin n_fail++; $display("FAIL rand_count: got %0d want %0d", s_ocount, e.c); end
          n_cmp++; if (s_olast !== e.l) begin n_fail++; $display("FAIL rand_last: got %b want %b", s_olast, e.l); end
        end
      end
      if (s_acc) begin
        sent++;
        m_lanes[lane_of(m_cnt)] = s_data;
        if (m_cnt == OW - 1 || s_last) begin
          for (int k = 0; k < OW; k++) f.d[k*IW +: IW] = m_lanes[k];
          f.c = CW'(m_cnt + 1);
          f.l = s_last;
          q.push_back(f);
          for (int k = 0; k < OW; k++) m_lanes[k] = '0;
          m_cnt = 0;
        end else begin
          m_cnt++;
        end
      end
      n_cmp++; if (o_valid !== (q.size() != 0)) begin n_fail++; $display("FAIL rand_valid: got %b want %b", o_valid, (q.size() != 0)); end
    end
    n_cmp++; if (sent != 400 || q.size() != 0) begin n_fail++; $display("FAIL rand_drain: sent %0d pending %0d want 400/0", sent, q.size()); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_short_frame();
    test_last_on_full();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
